vram_ram_clear: RTL and testbench
=================================

Name: vram_ram_clear

Overview:
- Single-clock, parametrised successor to the team's dual-clock simple RAM.
- One write port and one read port, with a read-valid strobe and a selectable read-during-write mode.
- A built-in clear sequencer fills every location with CLEAR_VALUE, either after reset or on request.
- Sits between the bus-capture logic and the video fetch logic, so video memory always starts from a known state.

Parameters:
- DATA_WIDTH, 8, width of the data bus.
- ADDR_WIDTH, 8, width of the address buses; depth is 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word written to every location by the clear sequencer.
- CLEAR_ON_RESET, 1, when 1 a full clear runs automatically on reset release.
- WRITE_FIRST, 1, when 1 a same-address read returns new data; when 0 it returns old data.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- data  input  DATA_WIDTH  write data.
- write_addr  input  ADDR_WIDTH  write address.
- we  input  1  write enable.
- read_addr  input  ADDR_WIDTH  read address.
- re  input  1  read enable.
- clear_req  input  1  request a full clear; single-cycle pulse or level.
- q  output  DATA_WIDTH  registered read data.
- q_valid  output  1  q updated by a read accepted the previous cycle.
- busy  output  1  clear in progress; external we/re ignored.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n low at a posedge):
  - q=0, q_valid=0, clear address counter=0.
  - state=CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state=IDLE and busy=0.
  - Memory contents are untouched by reset itself.
- States: IDLE and CLEAR; busy is 1 exactly while state==CLEAR.
- IDLE to CLEAR: clear_req=1 sampled at a posedge. Counter=0; busy rises the following cycle.
- CLEAR operation: each cycle, write CLEAR_VALUE at the counter, then counter+1.
- CLEAR exit: the cycle writing address 2**ADDR_WIDTH-1 returns to IDLE and resets the counter to 0.
  - A clear takes exactly 2**ADDR_WIDTH cycles.
  - busy falls on the posedge after the last write.
- clear_req while in CLEAR is ignored: no restart, no queueing.
- During CLEAR:
  - External we is ignored; the write is dropped, not deferred.
  - re is ignored; q holds and q_valid=0.
- Write in IDLE: we=1 at posedge n stores data at write_addr. Visible to reads issued at n+1 onward.
- Read in IDLE: re=1 at posedge n gives q=ram[read_addr] and q_valid=1 after posedge n, for one cycle per accepted read.
  - Latency is 1 cycle; back-to-back reads give q_valid held high.
  - re=0: q holds its last value and q_valid=0.
- Read and write to the same address in the same cycle:
  - WRITE_FIRST=1: q=data.
  - WRITE_FIRST=0: q=previous contents.
  - Different addresses: independent, no interaction.
- Reset mid-clear:
  - CLEAR_ON_RESET=1: the clear restarts from address 0.
  - CLEAR_ON_RESET=0: the clear aborts to IDLE; already-cleared locations stay cleared, the rest keep old data.
- Reset asserted with re=1: q_valid=0, q=0; the read is discarded.
- Addresses are full-range; the counter never exceeds 2**ADDR_WIDTH-1 and wraps to 0 only via the state exit.
- Storage must infer block RAM: one write mux (clear or external), a registered read, and the bypass mux after the RAM.
- No $readmemh initial load; the clear sequencer replaces it.

Test Plan:
- Auto-clear: ADDR_WIDTH=4, CLEAR_VALUE=8'hA5, CLEAR_ON_RESET=1; release reset_n.
  - busy stays high exactly 16 cycles.
  - Reads of addresses 0..15 then return 8'hA5 with q_valid=1 one cycle after each re.
- Write/read latency: in IDLE, write 8'h3C to address 7, next cycle re with read_addr=7.
  - q=8'h3C and q_valid=1 one cycle later.
  - With re low the following cycle, q_valid=0 and q holds 8'h3C.
- Read-during-write: address 5 holds 8'h11; same cycle, we=1 with data=8'h22 and re=1 at address 5.
  - WRITE_FIRST=1 build: q=8'h22.
  - WRITE_FIRST=0 build: q=8'h11, and the next read returns 8'h22.
- Blocked access during clear:
  - Pulse clear_req, then issue we to address 3 (data 8'hFF) and re on cycle 4 of the clear.
  - Required: q_valid stays 0 and address 3 reads CLEAR_VALUE after busy falls.
  - clear_req pulsed mid-clear does not extend busy beyond 16 cycles.
- Reset mid-clear: assert reset_n low for 1 cycle at clear cycle 9.
  - CLEAR_ON_RESET=1: busy stays high for 16 further cycles.
  - CLEAR_ON_RESET=0 with pre-written 8'h77 everywhere: addresses 0..8 read CLEAR_VALUE, 9..15 read 8'h77.
- Back-to-back reads: re high 4 cycles on addresses 0,1,2,3 holding 8'h00..8'h03.
  - q_valid high for 4 consecutive cycles with q=8'h00,01,02,03 in order.

Source files
------------

// File: rtl/vram_ram_clear.sv
// Single-clock video RAM: one write port, one registered read port with a
// valid strobe, selectable read-during-write behaviour and a clear sequencer
// that fills every location with CLEAR_VALUE after reset or on request.
module vram_ram_clear #(
    parameter int unsigned            DATA_WIDTH     = 8,
    parameter int unsigned            ADDR_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0,
    parameter bit                     CLEAR_ON_RESET = 1'b1,
    parameter bit                     WRITE_FIRST    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  re,
    input  logic                  clear_req,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;

    // Bypass / output-qualification registers that sit after the RAM.
    logic                    q_loaded;
    logic                    byp_sel;
    logic [DATA_WIDTH-1:0]   byp_data;

    // Port arbitration: the clear sequencer owns the write port while busy.
    logic                    wr_en_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic                    rd_en_c;

    // Single write mux (clear vs. external) and read acceptance; nothing is
    // accepted while reset is asserted.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = write_addr;
        wr_data_c = data;
        rd_en_c   = 1'b0;
        if (reset_n) begin
            if (state == CLEAR) begin
                wr_en_c   = 1'b1;
                wr_addr_c = clr_addr;
                wr_data_c = CLEAR_VALUE;
            end else begin
                wr_en_c   = we;
                rd_en_c   = re;
            end
        end
    end

    // Clear sequencer: walks every address once, then returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_addr <= '0;
            state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            busy     <= CLEAR_ON_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_addr == '1) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Registered RAM read; holds when no read is accepted (old-data semantics).
    always_ff @(posedge clk) begin
        if (rd_en_c) begin
            ram_q <= mem[read_addr];
        end
    end

    // Read strobe and bypass selection for same-address read-during-write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_valid  <= 1'b0;
            q_loaded <= 1'b0;
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else begin
            q_valid <= rd_en_c;
            if (rd_en_c) begin
                q_loaded <= 1'b1;
                byp_sel  <= WRITE_FIRST && wr_en_c && (write_addr == read_addr);
                byp_data <= data;
            end
        end
    end

    // Output mux after the RAM: zero until the first read, bypass on collision.
    assign q = !q_loaded ? '0 : (byp_sel ? byp_data : ram_q);

endmodule

// File: tb/tb_vram_ram_clear.sv
// Self-checking bench: two instances (auto-clear/write-first and
// manual-clear/read-first) checked against a word-array reference model.
module tb_vram_ram_clear;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  CV    = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n    [2];
    logic [7:0] data       [2];
    logic [3:0] write_addr [2];
    logic       we         [2];
    logic [3:0] read_addr  [2];
    logic       re         [2];
    logic       clear_req  [2];
    logic [7:0] q          [2];
    logic       q_valid    [2];
    logic       busy       [2];

    logic [7:0] ref_mem [2][DEPTH];
    logic [7:0] last_q  [2];

    int n_cmp = 0;
    int n_err = 0;

    vram_ram_clear #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_VALUE(8'hA5),
        .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n[0]), .data(data[0]),
        .write_addr(write_addr[0]), .we(we[0]), .read_addr(read_addr[0]),
        .re(re[0]), .clear_req(clear_req[0]), .q(q[0]),
        .q_valid(q_valid[0]), .busy(busy[0])
    );

    vram_ram_clear #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_VALUE(8'hA5),
        .CLEAR_ON_RESET(1'b0), .WRITE_FIRST(1'b0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n[1]), .data(data[1]),
        .write_addr(write_addr[1]), .we(we[1]), .read_addr(read_addr[1]),
        .re(re[1]), .clear_req(clear_req[1]), .q(q[1]),
        .q_valid(q_valid[1]), .busy(busy[1])
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int d);
        we[d] = 1'b0; re[d] = 1'b0; clear_req[d] = 1'b0;
    endtask

    task automatic write_word(input int d, input logic [3:0] a, input logic [7:0] v);
        we[d] = 1'b1; write_addr[d] = a; data[d] = v;
        cyc();
        we[d] = 1'b0;
        ref_mem[d][a] = v;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b0; quiet(d);
            data[d] = '0; write_addr[d] = '0; read_addr[d] = '0;
        end
        cyc(); cyc();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (q[d] !== 8'h00) begin n_err++; $display("FAIL reset_q[%0d] got %h want 00", d, q[d]); end
            n_cmp++;
            if (q_valid[d] !== 1'b0) begin n_err++; $display("FAIL reset_qv[%0d] got %b want 0", d, q_valid[d]); end
            last_q[d] = 8'h00;
        end
        n_cmp++;
        if (busy[0] !== 1'b1) begin n_err++; $display("FAIL reset_busy[0] got %b want 1", busy[0]); end
        n_cmp++;
        if (busy[1] !== 1'b0) begin n_err++; $display("FAIL reset_busy[1] got %b want 0", busy[1]); end
    endtask

    task automatic test_auto_clear();
        int n;
        reset_n[0] = 1'b1; reset_n[1] = 1'b1;
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin cyc(); n++; end
        n_cmp++;
        if (n != 16) begin n_err++; $display("FAIL auto_clear_len got %0d cycles want 16", n); end
        for (int a = 0; a < DEPTH; a++) ref_mem[0][a] = CV;
        n_cmp++;
        if (busy[1] !== 1'b0) begin n_err++; $display("FAIL no_auto_clear_busy got %b want 0", busy[1]); end
        for (int a = 0; a < DEPTH; a++) begin
            re[0] = 1'b1; read_addr[0] = 4'(a);
            cyc();
            n_cmp++;
            if (q_valid[0] !== 1'b1 || q[0] !== CV) begin
                n_err++; $display("FAIL auto_clear_read a=%0d got qv=%b q=%h want qv=1 q=%h", a, q_valid[0], q[0], CV);
            end
        end
        re[0] = 1'b0;
        last_q[0] = CV;
    endtask

    task automatic test_write_read(input int d);
        write_word(d, 4'd7, 8'h3C);
        re[d] = 1'b1; read_addr[d] = 4'd7;
        cyc();
        re[d] = 1'b0;
        n_cmp++;
        if (q_valid[d] !== 1'b1 || q[d] !== 8'h3C) begin
            n_err++; $display("FAIL wr_rd[%0d] got qv=%b q=%h want qv=1 q=3c", d, q_valid[d], q[d]);
        end
        cyc();
        n_cmp++;
        if (q_valid[d] !== 1'b0 || q[d] !== 8'h3C) begin
            n_err++; $display("FAIL wr_rd_hold[%0d] got qv=%b q=%h want qv=0 q=3c", d, q_valid[d], q[d]);
        end
        last_q[d] = 8'h3C;
    endtask

    task automatic test_rdw(input int d);
        logic [7:0] e;
        write_word(d, 4'd5, 8'h11);
        we[d] = 1'b1; write_addr[d] = 4'd5; data[d] = 8'h22;
        re[d] = 1'b1; read_addr[d] = 4'd5;
        cyc();
        quiet(d);
        e = (d == 0) ? 8'h22 : 8'h11;
        ref_mem[d][5] = 8'h22;
        n_cmp++;
        if (q_valid[d] !== 1'b1 || q[d] !== e) begin
            n_err++; $display("FAIL rdw[%0d] got qv=%b q=%h want qv=1 q=%h", d, q_valid[d], q[d], e);
        end
        re[d] = 1'b1; read_addr[d] = 4'd5;
        cyc();
        re[d] = 1'b0;
        n_cmp++;
        if (q[d] !== 8'h22) begin n_err++; $display("FAIL rdw_after[%0d] got %h want 22", d, q[d]); end
        last_q[d] = 8'h22;
    endtask

    task automatic test_random_ops(input int d);
        for (int a = 0; a < DEPTH; a++) write_word(d, 4'(a), 8'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic       w, r;
            logic [3:0] wa, ra;
            logic [7:0] wd, e;
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = (i % 4 == 0) ? wa : 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            we[d] = w; write_addr[d] = wa; data[d] = wd;
            re[d] = r; read_addr[d] = ra;
            cyc();
            if (!r)                         e = last_q[d];
            else if (w && wa == ra && d == 0) e = wd;
            else                            e = ref_mem[d][ra];
            if (w) ref_mem[d][wa] = wd;
            n_cmp++;
            if (q_valid[d] !== r || q[d] !== e) begin
                n_err++; $display("FAIL random[%0d] i=%0d got qv=%b q=%h want qv=%b q=%h", d, i, q_valid[d], q[d], r, e);
            end
            last_q[d] = e;
        end
        quiet(d);
    endtask

    task automatic test_back_to_back(input int d);
        for (int a = 0; a < 4; a++) write_word(d, 4'(a), 8'(a));
        for (int a = 0; a < 4; a++) begin
            re[d] = 1'b1; read_addr[d] = 4'(a);
            cyc();
            n_cmp++;
            if (q_valid[d] !== 1'b1 || q[d] !== 8'(a)) begin
                n_err++; $display("FAIL b2b[%0d] a=%0d got qv=%b q=%h want qv=1 q=%h", d, a, q_valid[d], q[d], 8'(a));
            end
        end
        re[d] = 1'b0;
        last_q[d] = 8'h03;
    endtask

    task automatic test_blocked_clear();
        int n;
        clear_req[0] = 1'b1;
        cyc();
        clear_req[0] = 1'b0;
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin
            if (n == 3) begin
                we[0] = 1'b1; write_addr[0] = 4'd3; data[0] = 8'hFF;
                re[0] = 1'b1; read_addr[0] = 4'd3; clear_req[0] = 1'b1;
            end
            cyc();
            n++;
            quiet(0);
            n_cmp++;
            if (q_valid[0] !== 1'b0 || q[0] !== last_q[0]) begin
                n_err++; $display("FAIL blocked_read n=%0d got qv=%b q=%h want qv=0 q=%h", n, q_valid[0], q[0], last_q[0]);
            end
        end
        n_cmp++;
        if (n != 16) begin n_err++; $display("FAIL blocked_clear_len got %0d want 16", n); end
        for (int a = 0; a < DEPTH; a++) ref_mem[0][a] = CV;
        re[0] = 1'b1; read_addr[0] = 4'd3;
        cyc();
        re[0] = 1'b0;
        n_cmp++;
        if (q[0] !== CV) begin n_err++; $display("FAIL blocked_write_dropped got %h want %h", q[0], CV); end
        last_q[0] = CV;
    endtask

    task automatic test_reset_mid_clear_auto();
        int n;
        clear_req[0] = 1'b1;
        cyc();
        clear_req[0] = 1'b0;
        repeat (9) cyc();
        reset_n[0] = 1'b0;
        cyc();
        reset_n[0] = 1'b1;
        n_cmp++;
        if (q_valid[0] !== 1'b0 || q[0] !== 8'h00) begin
            n_err++; $display("FAIL rst_mid_out got qv=%b q=%h want qv=0 q=00", q_valid[0], q[0]);
        end
        last_q[0] = 8'h00;
        n = 0;
        while (busy[0] === 1'b1 && n < 40) begin cyc(); n++; end
        n_cmp++;
        if (n != 16) begin n_err++; $display("FAIL rst_mid_restart got %0d want 16", n); end
    endtask

    task automatic test_reset_mid_clear_abort();
        for (int a = 0; a < DEPTH; a++) write_word(1, 4'(a), 8'h77);
        clear_req[1] = 1'b1;
        cyc();
        clear_req[1] = 1'b0;
        repeat (9) cyc();
        reset_n[1] = 1'b0;
        cyc();
        reset_n[1] = 1'b1;
        n_cmp++;
        if (busy[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_abort_busy got %b want 0", busy[1]); end
        for (int a = 0; a < DEPTH; a++) ref_mem[1][a] = (a < 9) ? CV : 8'h77;
        for (int a = 0; a < DEPTH; a++) begin
            re[1] = 1'b1; read_addr[1] = 4'(a);
            cyc();
            n_cmp++;
            if (q[1] !== ref_mem[1][a]) begin
                n_err++; $display("FAIL rst_mid_abort a=%0d got %h want %h", a, q[1], ref_mem[1][a]);
            end
        end
        re[1] = 1'b0;
        last_q[1] = ref_mem[1][15];
    endtask

    task automatic test_reset_during_read();
        write_word(1, 4'd2, 8'h5A);
        re[1] = 1'b1; read_addr[1] = 4'd2;
        cyc();
        n_cmp++;
        if (q[1] !== 8'h5A) begin n_err++; $display("FAIL pre_rst_read got %h want 5a", q[1]); end
        reset_n[1] = 1'b0;
        cyc();
        reset_n[1] = 1'b1; re[1] = 1'b0;
        n_cmp++;
        if (q_valid[1] !== 1'b0 || q[1] !== 8'h00) begin
            n_err++; $display("FAIL rst_read_discard got qv=%b q=%h want qv=0 q=00", q_valid[1], q[1]);
        end
        last_q[1] = 8'h00;
    endtask

    initial begin
        test_reset();
        test_auto_clear();
        test_write_read(0);
        test_write_read(1);
        test_rdw(0);
        test_rdw(1);
        test_random_ops(0);
        test_random_ops(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_blocked_clear();
        test_reset_mid_clear_auto();
        test_reset_mid_clear_abort();
        test_reset_during_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
